uart_transmitter: RTL

- Serial UART transmitter; the transmit-side counterpart of the uart_receiver path.
- Accepts parallel bytes over a valid/ready handshake and serialises each one on tx.
- Frame format: 1 start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
- Bit timing comes from an internal down-counter. A bit period is BAUD_RATE_NUMBER clk cycles, the same timing constant the receive-side baud generator uses.

---
 rtl/uart_transmitter_if.sv | 20 ++
 rtl/uart_transmitter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_if.sv
// Byte-wide valid/ready handshake between an upstream producer and the UART transmitter.
interface uart_transmitter_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a byte over valid/ready and serialises it as
// start bit, LSB-first data bits, optional parity bit and stop bit(s).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, ready for a new byte
// START  | driving the start bit (0)
// DATA   | driving data bits LSB first, shift register moves right
// PARITY | driving the parity bit computed when the byte was accepted
// STOP   | driving stop bit(s) (1); bit index counts stop periods
module uart_transmitter #(
    parameter int BAUD_RATE_NUMBER = 10416,
    parameter int DATA_BITS        = 8,
    parameter int PARITY_EN        = 0,
    parameter int PARITY_ODD       = 0,
    parameter int STOP_BITS        = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_transmitter_if.slave   bus,
    output logic                tx,
    output logic                busy
);

    localparam int CNT_W = $clog2(BAUD_RATE_NUMBER);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_RELOAD    = CNT_W'(BAUD_RATE_NUMBER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_SEL       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    // State, baud counter and datapath registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_RELOAD;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign bit_end = (cnt_q == '0);

    // Next state and next line value; every bit boundary is the counter hitting 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;

        if (state_q == S_IDLE) begin
            tx_d = 1'b1;
            if (bus.tx_valid) begin
                state_d  = S_START;
                cnt_d    = CNT_RELOAD;
                idx_d    = '0;
                shift_d  = bus.tx_data;
                parity_d = (^bus.tx_data) ^ ODD_SEL;
                tx_d     = 1'b0;
            end
        end else begin
            // Reload wins at zero so the counter never wraps below 0.
            cnt_d = bit_end ? CNT_RELOAD : (cnt_q - CNT_W'(1));
            if (bit_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        tx_d    = shift_q[0];
                    end
                    S_DATA: begin
                        shift_d = shift_q >> 1;
                        if (idx_q == IDX_LAST_DATA) begin
                            idx_d = '0;
                            if (PARITY_EN != 0) begin
                                state_d = S_PARITY;
                                tx_d    = parity_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                            tx_d  = shift_q[1];
                        end
                    end
                    S_PARITY: begin
                        state_d = S_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end
                    S_STOP: begin
                        tx_d = 1'b1;
                        if (idx_q == IDX_LAST_STOP) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end
                endcase
            end
        end
    end

    // Handshake and status decoded purely from the registered state.
    always_comb begin
        bus.tx_ready = (state_q == S_IDLE);
        busy         = (state_q != S_IDLE);
    end

    assign tx = tx_q;

endmodule
